// File: rtl/cmd_pkg.sv
// Shared types and defaults for the command register bus arbiter.
package cmd_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [7:0] RST_ADDR_DEF = 8'h01;
    localparam logic [7:0] RST_DATA_DEF = 8'h02;

    localparam logic REQ_VJTAG  = 1'b0;
    localparam logic REQ_EXPORT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StAddr,
        StWrite,
        StDone,
        StSrst
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmd_bus_arbiter_if.sv
// Requester handshakes and register bus signals of the command bus arbiter.
interface cmd_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              j_req;
    logic              j_we;
    logic [ADDR_W-1:0] j_addr;
    logic [DATA_W-1:0] j_data;
    logic              j_gnt;
    logic              j_done;

    logic              e_req;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_gnt;
    logic              e_done;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_wr;

    modport master (
        input  j_req, j_we, j_addr, j_data,
        input  e_req, e_we, e_addr, e_data,
        output j_gnt, j_done, e_gnt, e_done,
        output bus_addr, bus_data, bus_wr
    );

    modport slave (
        output j_req, j_we, j_addr, j_data,
        output e_req, e_we, e_addr, e_data,
        input  j_gnt, j_done, e_gnt, e_done,
        input  bus_addr, bus_data, bus_wr
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last time wins.
module rr_arb2
    import cmd_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last == REQ_EXPORT) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Shares the command register bus between the vjtag and export requesters, sequencing
// address and write phases, the soft-reset command and init requests.
module cmd_bus_arbiter
    import cmd_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       DATA_W     = DATA_W_DEF,
    parameter int unsigned       ADDR_HOLD  = 3,
    parameter int unsigned       STROBE_CYC = 3,
    parameter int unsigned       RST_CYC    = 50000,
    parameter logic [ADDR_W-1:0] RST_ADDR   = ADDR_W'(RST_ADDR_DEF),
    parameter logic [DATA_W-1:0] RST_DATA   = DATA_W'(RST_DATA_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    cmd_bus_arbiter_if.master bus,
    output logic              soft_reset_out,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(max3(ADDR_HOLD, STROBE_CYC, RST_CYC) + 1);
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t AddrLoad   = cnt_t'(ADDR_HOLD - 1);
    localparam cnt_t StrobeLoad = cnt_t'(STROBE_CYC - 1);
    localparam cnt_t RstLoad    = cnt_t'(RST_CYC - 1);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              init_pend_q, init_pend_d;
    logic              init_clr;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              bus_wr_q, bus_wr_d;
    logic              srst_q, srst_d;

    logic [1:0]        req;
    logic [1:0]        arb_gnt;
    logic              arb_en;

    assign req    = {bus.e_req, bus.j_req};
    assign arb_en = (state_q == StIdle) && !init_pend_q;

    rr_arb2 u_arb (
        .req    (req),
        .last   (last_q),
        .enable (arb_en),
        .gnt    (arb_gnt)
    );

    // init is latched at every edge; a new pulse wins over the clear.
    assign init_pend_d = init | (init_pend_q & ~init_clr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_wr_d   = bus_wr_q;
        srst_d     = srst_q;
        init_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_pend_q) begin
                    state_d = StInit;
                end else if (arb_gnt != 2'b00) begin
                    owner_d    = arb_gnt[REQ_EXPORT];
                    we_d       = owner_d ? bus.e_we : bus.j_we;
                    addr_d     = owner_d ? bus.e_addr : bus.j_addr;
                    data_d     = owner_d ? bus.e_data : bus.j_data;
                    bus_addr_d = addr_d;
                    gnt_d      = arb_gnt;
                    last_d     = owner_d;
                    cnt_d      = AddrLoad;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        bus_data_d = data_q;
                        bus_wr_d   = 1'b1;
                        cnt_d      = StrobeLoad;
                        state_d    = StWrite;
                    end else begin
                        done_d[owner_q] = 1'b1;
                        state_d         = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StWrite: begin
                if (cnt_q == '0) begin
                    bus_wr_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    state_d         = StDone;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StDone: begin
                if (we_q && (addr_q == RST_ADDR) && (data_q == RST_DATA)) begin
                    srst_d     = 1'b1;
                    bus_addr_d = '0;
                    cnt_d      = RstLoad;
                    state_d    = StSrst;
                end else begin
                    state_d = StIdle;
                end
            end
            StSrst: begin
                if (cnt_q == '0) begin
                    srst_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StInit: begin
                bus_addr_d = '0;
                init_clr   = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= REQ_EXPORT;
            init_pend_q <= 1'b0;
            owner_q     <= REQ_VJTAG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_wr_q    <= 1'b0;
            srst_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            init_pend_q <= init_pend_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_wr_q    <= bus_wr_d;
            srst_q      <= srst_d;
        end
    end

    assign bus.j_gnt      = gnt_q[REQ_VJTAG];
    assign bus.e_gnt      = gnt_q[REQ_EXPORT];
    assign bus.j_done     = done_q[REQ_VJTAG];
    assign bus.e_done     = done_q[REQ_EXPORT];
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_data   = bus_data_q;
    assign bus.bus_wr     = bus_wr_q;
    assign soft_reset_out = srst_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed self-checking bench for cmd_bus_arbiter with a 16-cycle soft-reset pulse.
module tb_cmd_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic init;
    logic soft_reset_out;
    logic busy;

    int checks = 0;
    int passed = 0;

    cmd_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

    cmd_bus_arbiter #(.RST_CYC(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .bus            (bus_if),
        .soft_reset_out (soft_reset_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init          = 1'b0;
        bus_if.j_req  = 1'b0;
        bus_if.j_we   = 1'b0;
        bus_if.j_addr = 8'h00;
        bus_if.j_data = 8'h00;
        bus_if.e_req  = 1'b0;
        bus_if.e_we   = 1'b0;
        bus_if.e_addr = 8'h00;
        bus_if.e_data = 8'h00;
    endtask

    task automatic wait_gnt(input logic want_e, output int n);
        n = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if ((want_e ? bus_if.e_gnt : bus_if.j_gnt) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if ({busy, soft_reset_out, bus_if.bus_wr} !== 3'b000)
            $display("FAIL reset_ctl: got %b expected 000", {busy, soft_reset_out, bus_if.bus_wr});
        else passed++;
        checks++;
        if (bus_if.bus_addr !== 8'h00)
            $display("FAIL reset_addr: got %h expected 00", bus_if.bus_addr);
        else passed++;
        checks++;
        if (bus_if.bus_data !== 8'h00)
            $display("FAIL reset_data: got %h expected 00", bus_if.bus_data);
        else passed++;
        checks++;
        if ({bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done, bus_if.e_done} !== 4'b0000)
            $display("FAIL reset_handshake: got %b expected 0000",
                     {bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done, bus_if.e_done});
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_vjtag_write();
        int n;
        logic [5:0] got, exp;
        bus_if.j_req  = 1'b1;
        bus_if.j_we   = 1'b1;
        bus_if.j_addr = 8'h10;
        bus_if.j_data = 8'h5A;
        wait_gnt(1'b0, n);
        checks++;
        if (n < 0) $display("FAIL vjtag_write_gnt: got timeout expected j_gnt");
        else passed++;
        // Operands and req move after the grant; the captured values must be used.
        bus_if.j_req  = 1'b0;
        bus_if.j_addr = 8'hFF;
        bus_if.j_data = 8'h00;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            got = {bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done, bus_if.e_done, bus_if.bus_wr, busy};
            exp = {k == 0, 1'b0, k == 6, 1'b0, (k >= 3) && (k <= 5), k <= 6};
            checks++;
            if (got !== exp) $display("FAIL vjtag_write_ctl k=%0d: got %b expected %b", k, got, exp);
            else passed++;
            checks++;
            if (bus_if.bus_addr !== 8'h10)
                $display("FAIL vjtag_write_addr k=%0d: got %h expected 10", k, bus_if.bus_addr);
            else passed++;
            if (k >= 3) begin
                checks++;
                if (bus_if.bus_data !== 8'h5A)
                    $display("FAIL vjtag_write_data k=%0d: got %h expected 5a", k, bus_if.bus_data);
                else passed++;
            end
        end
    endtask

    task automatic test_export_addr_only();
        int n;
        logic [5:0] got, exp;
        bus_if.e_req  = 1'b1;
        bus_if.e_we   = 1'b0;
        bus_if.e_addr = 8'h33;
        bus_if.e_data = 8'hEE;
        wait_gnt(1'b1, n);
        checks++;
        if (n < 0) $display("FAIL export_gnt: got timeout expected e_gnt");
        else passed++;
        bus_if.e_req = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            got = {bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done, bus_if.e_done, bus_if.bus_wr, busy};
            exp = {1'b0, k == 0, 1'b0, k == 3, 1'b0, k <= 3};
            checks++;
            if (got !== exp) $display("FAIL export_ctl k=%0d: got %b expected %b", k, got, exp);
            else passed++;
            checks++;
            if ({bus_if.bus_addr, bus_if.bus_data} !== 16'h335A)
                $display("FAIL export_bus k=%0d: got %h expected 335a", k,
                         {bus_if.bus_addr, bus_if.bus_data});
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int ng = 0;
        int overlaps = 0;
        int n;
        logic order[4];
        logic [7:0] addr_at[4];
        logic exp_o;
        reset = 1'b0;
        idle_inputs();
        bus_if.j_req  = 1'b1;
        bus_if.e_req  = 1'b1;
        bus_if.j_addr = 8'hA1;
        bus_if.e_addr = 8'hB2;
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            tick();
            if ((bus_if.j_gnt && bus_if.e_gnt) || (bus_if.j_done && bus_if.e_done) ||
                ((bus_if.j_gnt || bus_if.e_gnt) && (bus_if.j_done || bus_if.e_done)))
                overlaps++;
            if (bus_if.j_gnt || bus_if.e_gnt) begin
                order[ng]   = bus_if.e_gnt;
                addr_at[ng] = bus_if.bus_addr;
                ng++;
            end
        end
        checks++;
        if (ng !== 4) $display("FAIL b2b_count: got %0d expected 4", ng);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_o = (i % 2 == 1);
            checks++;
            if (order[i] !== exp_o) $display("FAIL b2b_order i=%0d: got %b expected %b", i, order[i], exp_o);
            else passed++;
            checks++;
            if (addr_at[i] !== (exp_o ? 8'hB2 : 8'hA1))
                $display("FAIL b2b_addr i=%0d: got %h expected %h", i, addr_at[i],
                         exp_o ? 8'hB2 : 8'hA1);
            else passed++;
        end
        checks++;
        if (overlaps !== 0) $display("FAIL b2b_overlap: got %0d expected 0", overlaps);
        else passed++;
        bus_if.j_req = 1'b0;
        bus_if.e_req = 1'b0;
        wait_idle(n);
        checks++;
        if (n < 0) $display("FAIL b2b_drain: got timeout expected idle");
        else passed++;
    endtask

    task automatic test_soft_reset();
        int n;
        int srst_len = 0;
        logic [2:0] got, exp;
        bus_if.j_req  = 1'b1;
        bus_if.j_we   = 1'b1;
        bus_if.j_addr = 8'h01;
        bus_if.j_data = 8'h02;
        wait_gnt(1'b0, n);
        checks++;
        if (n < 0) $display("FAIL srst_gnt: got timeout expected j_gnt");
        else passed++;
        bus_if.j_req  = 1'b0;
        bus_if.e_we   = 1'b0;
        bus_if.e_addr = 8'h44;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (bus_if.j_done !== 1'b1) $display("FAIL srst_done: got %b expected 1", bus_if.j_done);
                else passed++;
                bus_if.e_req = 1'b1;
            end
            if (k >= 7) begin
                got = {soft_reset_out, bus_if.e_gnt, busy};
                exp = {k <= 22, k == 24, k != 23};
                checks++;
                if (got !== exp) $display("FAIL srst_ctl k=%0d: got %b expected %b", k, got, exp);
                else passed++;
                if (soft_reset_out === 1'b1) srst_len++;
            end
            if (k >= 7 && k <= 22) begin
                checks++;
                if (bus_if.bus_addr !== 8'h00)
                    $display("FAIL srst_addr k=%0d: got %h expected 00", k, bus_if.bus_addr);
                else passed++;
            end
        end
        checks++;
        if (srst_len !== 16) $display("FAIL srst_len: got %0d expected 16", srst_len);
        else passed++;
        checks++;
        if (bus_if.bus_addr !== 8'h44) $display("FAIL srst_next_addr: got %h expected 44", bus_if.bus_addr);
        else passed++;
        bus_if.e_req = 1'b0;
        wait_idle(n);
        checks++;
        if (n < 0) $display("FAIL srst_drain: got timeout expected idle");
        else passed++;
    endtask

    task automatic test_init_during_write();
        int n;
        logic [3:0] got, exp;
        logic [7:0] exp_addr;
        bus_if.j_req  = 1'b1;
        bus_if.j_we   = 1'b1;
        bus_if.j_addr = 8'h20;
        bus_if.j_data = 8'h77;
        wait_gnt(1'b0, n);
        checks++;
        if (n < 0) $display("FAIL init_gnt: got timeout expected j_gnt");
        else passed++;
        bus_if.j_req  = 1'b0;
        bus_if.e_we   = 1'b0;
        bus_if.e_addr = 8'h55;
        for (int k = 1; k <= 10; k++) begin
            tick();
            got      = {busy, bus_if.bus_wr, bus_if.j_done, bus_if.e_gnt};
            exp      = {(k != 7) && (k != 9), (k >= 3) && (k <= 5), k == 6, k == 10};
            exp_addr = (k <= 8) ? 8'h20 : ((k == 9) ? 8'h00 : 8'h55);
            checks++;
            if (got !== exp) $display("FAIL init_ctl k=%0d: got %b expected %b", k, got, exp);
            else passed++;
            checks++;
            if (bus_if.bus_addr !== exp_addr)
                $display("FAIL init_addr k=%0d: got %h expected %h", k, bus_if.bus_addr, exp_addr);
            else passed++;
            if (k == 4) begin
                init         = 1'b1;
                bus_if.e_req = 1'b1;
            end
            if (k == 5) init = 1'b0;
        end
        checks++;
        if (bus_if.bus_data !== 8'h77) $display("FAIL init_data: got %h expected 77", bus_if.bus_data);
        else passed++;
        bus_if.e_req = 1'b0;
        wait_idle(n);
        checks++;
        if (n < 0) $display("FAIL init_drain: got timeout expected idle");
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        bus_if.j_req  = 1'b1;
        bus_if.j_we   = 1'b1;
        bus_if.j_addr = 8'h66;
        bus_if.j_data = 8'h99;
        wait_gnt(1'b0, n);
        checks++;
        if (n < 0) $display("FAIL rmid_gnt: got timeout expected j_gnt");
        else passed++;
        bus_if.j_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus_if.bus_wr !== 1'b1) $display("FAIL rmid_wr: got %b expected 1", bus_if.bus_wr);
        else passed++;
        reset         = 1'b0;
        bus_if.j_req  = 1'b1;
        bus_if.j_we   = 1'b0;
        bus_if.e_req  = 1'b1;
        bus_if.e_we   = 1'b0;
        bus_if.e_addr = 8'h77;
        tick();
        checks++;
        if ({bus_if.bus_wr, busy, bus_if.j_done, bus_if.e_done, soft_reset_out} !== 5'b00000)
            $display("FAIL rmid_ctl: got %b expected 00000",
                     {bus_if.bus_wr, busy, bus_if.j_done, bus_if.e_done, soft_reset_out});
        else passed++;
        checks++;
        if (bus_if.bus_addr !== 8'h00) $display("FAIL rmid_addr: got %h expected 00", bus_if.bus_addr);
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if ({bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done} !== 3'b100)
            $display("FAIL rmid_tie: got %b expected 100", {bus_if.j_gnt, bus_if.e_gnt, bus_if.j_done});
        else passed++;
        checks++;
        if (bus_if.bus_addr !== 8'h66) $display("FAIL rmid_tie_addr: got %h expected 66", bus_if.bus_addr);
        else passed++;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_vjtag_write();
        test_export_addr_only();
        test_back_to_back();
        test_soft_reset();
        test_init_during_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
